// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: clears registers 1..2^ADDR_WIDTH-1 after reset,
// then arbitrates two write requesters onto a single write port.
module rf_write_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  init_done
);

   typedef enum logic {
      INIT = 1'b0,
      ARB  = 1'b1
   } state_t;

   // Last register address to clear; register 0 is never written.
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_ptr;

   logic                  w_arb;
   logic                  w_gnt0;
   logic                  w_gnt1;

   // State and clear counter; counter only advances while clearing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= INIT;
         r_cnt   <= ADDR_WIDTH'(1);
      end else begin
         case (r_state)
            INIT: begin
               r_cnt <= r_cnt + ADDR_WIDTH'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= ARB;
               end
            end
            ARB: begin
               r_state <= ARB;
            end
            default: begin
               r_state <= INIT;
            end
         endcase
      end
   end

   // Priority pointer: after a transfer, favour the requester that lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 1'b0;
      end else if (w_gnt0) begin
         r_ptr <= 1'b1;
      end else if (w_gnt1) begin
         r_ptr <= 1'b0;
      end
   end

   // Grant decode; a grant always coincides with a transfer since it requires valid.
   assign w_arb  = (r_state == ARB) && !rst;
   assign w_gnt0 = w_arb && req0_valid && (!req1_valid || !r_ptr);
   assign w_gnt1 = w_arb && req1_valid && (!req0_valid ||  r_ptr);

   // Write-port mux; rst forces everything low so no write lands during reset.
   always_comb begin
      rf_wen     = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst) begin
         if (r_state == INIT) begin
            rf_wen   = 1'b1;
            rf_waddr = r_cnt;
         end else if (w_gnt0) begin
            req0_ready = 1'b1;
            rf_waddr   = req0_addr;
            rf_wdata   = req0_data;
            rf_wen     = |req0_addr;
         end else if (w_gnt1) begin
            req1_ready = 1'b1;
            rf_waddr   = req1_addr;
            rf_wdata   = req1_data;
            rf_wen     = |req1_addr;
         end
      end
   end

   assign init_done = (r_state == ARB) && !rst;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter at default parameters.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_addr, req1_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        init_done;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .init_done  (init_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance exactly one rising edge; land mid low phase, away from it.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".wen"},  64'(rf_wen), 64'd0);
      chk({tag, ".addr"}, 64'(rf_waddr), 64'd0);
      chk({tag, ".data"}, 64'(rf_wdata), 64'd0);
      chk({tag, ".rdy0"}, 64'(req0_ready), 64'd0);
      chk({tag, ".rdy1"}, 64'(req1_ready), 64'd0);
      chk({tag, ".done"}, 64'(init_done), 64'd0);
   endtask

   // Full clear sequence: addresses 1..31, then ARB on the next cycle.
   task automatic run_init(input string tag);
      for (int i = 1; i <= 31; i++) begin
         chk({tag, ".wen"},  64'(rf_wen), 64'd1);
         chk({tag, ".addr"}, 64'(rf_waddr), 64'(i));
         chk({tag, ".data"}, 64'(rf_wdata), 64'd0);
         chk({tag, ".rdy0"}, 64'(req0_ready), 64'd0);
         chk({tag, ".rdy1"}, 64'(req1_ready), 64'd0);
         chk({tag, ".done"}, 64'(init_done), 64'd0);
         cyc();
      end
      chk({tag, ".done_after"}, 64'(init_done), 64'd1);
   endtask

   initial begin
      logic [4:0] exp_addr [4];
      logic       exp_g0   [4];
      exp_addr[0] = 5'd3; exp_addr[1] = 5'd7; exp_addr[2] = 5'd3; exp_addr[3] = 5'd7;
      exp_g0[0]   = 1'b1; exp_g0[1]   = 1'b0; exp_g0[2]   = 1'b1; exp_g0[3]   = 1'b0;

      rst = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      cyc();
      cyc();
      chk_all_zero("reset");

      // Clear sequence with no requests.
      rst = 1'b0;
      #1;
      run_init("init");
      chk("idle.wen",  64'(rf_wen), 64'd0);
      chk("idle.addr", 64'(rf_waddr), 64'd0);
      chk("idle.data", 64'(rf_wdata), 64'd0);

      // Single req0 write, same-cycle ready and write.
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      #1;
      chk("r0.rdy0", 64'(req0_ready), 64'd1);
      chk("r0.rdy1", 64'(req1_ready), 64'd0);
      chk("r0.wen",  64'(rf_wen), 64'd1);
      chk("r0.addr", 64'(rf_waddr), 64'd5);
      chk("r0.data", 64'(rf_wdata), 64'hDEADBEEF);
      cyc();
      req0_valid = 1'b0;

      // req1 to register 0: accepted but write suppressed; pointer returns to 0.
      req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
      #1;
      chk("a0.rdy1", 64'(req1_ready), 64'd1);
      chk("a0.rdy0", 64'(req0_ready), 64'd0);
      chk("a0.wen",  64'(rf_wen), 64'd0);
      cyc();
      req1_valid = 1'b0;
      #1;
      chk("a0.after_rdy1", 64'(req1_ready), 64'd0);

      // Both requesting: grants alternate starting with req0.
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333_0000;
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h7777_0000;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr.rdy0", 64'(req0_ready), 64'(exp_g0[k]));
         chk("rr.rdy1", 64'(req1_ready), 64'(!exp_g0[k]));
         chk("rr.addr", 64'(rf_waddr), 64'(exp_addr[k]));
         chk("rr.data", 64'(rf_wdata), exp_g0[k] ? 64'h3333_0000 : 64'h7777_0000);
         chk("rr.wen",  64'(rf_wen), 64'd1);
         cyc();
      end

      // Reset mid-transfer drops the request and zeroes outputs.
      rst = 1'b1;
      #1;
      chk_all_zero("rst_xfer");
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();
      rst = 1'b0;
      #1;

      // Reset at INIT cycle 10 for two cycles, then a full restart.
      for (int i = 1; i < 10; i++) cyc();
      chk("c10.addr", 64'(rf_waddr), 64'd10);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_init0");
      cyc();
      chk_all_zero("rst_init1");
      cyc();
      rst = 1'b0;
      // Requests pending throughout the restarted clear sequence.
      req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'hA5A5_0009;
      req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h5A5A_000A;
      #1;
      run_init("reinit");
      chk("first.rdy0", 64'(req0_ready), 64'd1);
      chk("first.rdy1", 64'(req1_ready), 64'd0);
      chk("first.addr", 64'(rf_waddr), 64'd9);
      chk("first.data", 64'(rf_wdata), 64'hA5A5_0009);
      cyc();
      req0_valid = 1'b0;
      #1;
      chk("second.rdy1", 64'(req1_ready), 64'd1);
      chk("second.addr", 64'(rf_waddr), 64'd10);
      chk("second.wen",  64'(rf_wen), 64'd1);
      cyc();
      req1_valid = 1'b0;
      #1;
      chk("end.wen", 64'(rf_wen), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
